pipeline_stage_reg: RTL and testbench
=====================================

// Module: pipeline_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready
//  handshake, flush and bubble insertion. Payload split into data (held as-is) and
//  control (forced to 0 on any bubble, so no write enable fires from a dead slot).
//  Saturating stall counter for performance debug.
// PARAMETERS
//  DATA_WIDTH    96  payload bits carried unmodified (pc, operands, imm, rd, ...)
//  CTRL_WIDTH    16  control bits zeroed on bubble/flush (wren, src selects, operators)
//  STALL_CNT_W   16  width of saturating stall counter
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            asynchronous, active-high
//  flush      in   1            kill stage contents (branch mispredict/redirect)
//  in_valid   in   1            upstream slot valid
//  in_ready   out  1            stage accepts in_* this cycle
//  in_data    in   DATA_WIDTH   upstream payload
//  in_ctrl    in   CTRL_WIDTH   upstream control
//  out_valid  out  1            downstream slot valid
//  out_ready  in   1            downstream accepts out_* this cycle
//  out_data   out  DATA_WIDTH   registered payload
//  out_ctrl   out  CTRL_WIDTH   registered control; 0 whenever out_valid=0
//  stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 && out_ready=0, saturating
// BEHAVIOUR
//  - Reset (async): out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, skid empty;
//    in_ready=1 from first edge after reset deasserts. Mid-operation reset drops all slots.
//  - Transfer in: in_valid && in_ready at posedge. Transfer out: out_valid && out_ready.
//  - Latency 1 cycle in->out when not stalled; throughput 1/cycle.
//  - States: EMPTY (out_valid=0), FULL (main reg valid), SKID (main+skid valid, macro only).
//    EMPTY: accept -> FULL.  FULL: out taken & in accepted -> FULL (new data);
//    out taken only -> EMPTY; in accepted, out not taken -> SKID (macro) / n.a. (no macro).
//    SKID: out taken -> FULL, main <= skid, in_ready=0 that cycle.
//  - flush: highest priority; at posedge clears out_valid, skid, out_ctrl=0; out_data held.
//    in_* presented during flush cycle is discarded (not accepted) regardless of in_ready.
//  - Bubble: whenever out_valid=0, out_ctrl=0 (registered, not gated combinationally).
//  - out_data/out_ctrl stable while out_valid && !out_ready (no change under stall).
//  - stall_cnt += 1 each cycle out_valid && !out_ready && !flush; holds at 2^STALL_CNT_W-1.
//    Cleared only by reset.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined:
//    2-entry (main+skid) buffer; in_ready is a flop = !skid_valid (no comb. path out_ready->in_ready).
//    Accepts one extra beat after downstream stalls; ordering preserved (main before skid).
//  PIPE_STAGE_SKID_EN undefined:
//    single entry; in_ready = !out_valid || out_ready (combinational); SKID state absent.
//  Cycle-level output behaviour identical in both builds when out_ready is held at 1.
// TESTING
//  1 Reset: assert reset mid-stream with out_valid=1 -> out_valid=0, out_ctrl=0, stall_cnt=0 immediately (async).
//  2 Streaming: in_valid=1, out_ready=1, data 1,2,3,4 -> out_data 1,2,3,4 one cycle later, no gaps.
//  3 Stall: load 0xA, hold out_ready=0 3 cycles -> out_data=0xA stable, stall_cnt=3; skid build
//    accepts 0xB then in_ready=0; release -> out 0xA then 0xB.
//  4 Flush: FULL with ctrl=0xFFFF, flush=1 with in_valid=1 data 0xC -> next cycle out_valid=0,
//    out_ctrl=0, 0xC never appears at output.
//  5 Bubble: in_valid=0 with in_ctrl=0xFFFF driven -> out_ctrl stays 0.
//  6 Saturation: STALL_CNT_W=4, stall 20 cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: valid/ready pipeline register with flush, bubble-zeroed control and stall counter.
// Defining PIPE_STAGE_SKID_EN adds a skid entry and a registered in_ready.
module pipeline_stage_reg #(
  parameter int DATA_WIDTH  = 96,
  parameter int CTRL_WIDTH  = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   acc, take;
  assign take      = valid_q && out_ready;
  assign acc       = in_valid && in_ready && !flush;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;
  assign stall_cnt = cnt_q;
  assign cnt_d     = (valid_q && !out_ready && !flush && !(&cnt_q)) ? cnt_q + STALL_CNT_W'(1) : cnt_q;
`ifdef PIPE_STAGE_SKID_EN
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic                  rdy_q;
  assign in_ready = rdy_q;
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      valid_d      = 1'b0;
      ctrl_d       = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (skid_valid_q) begin
      if (take) begin
        data_d       = skid_data_q;
        ctrl_d       = skid_ctrl_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end
    end else if (acc && valid_q && !out_ready) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end else if (acc) begin
      valid_d = 1'b1;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end else if (take) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      rdy_q        <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      rdy_q        <= !skid_valid_d;
    end
  end
`else
  assign in_ready = !valid_q || out_ready;
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (acc) begin
      valid_d = 1'b1;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end else if (take) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb_pipeline_stage_reg: directed checks of pipeline_stage_reg with a 4-bit stall counter.
module tb_pipeline_stage_reg;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [95:0] in_data, out_data;
  logic [15:0] in_ctrl, out_ctrl;
  logic [3:0]  stall_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  pipeline_stage_reg #(.DATA_WIDTH(96), .CTRL_WIDTH(16), .STALL_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_ctrl = '0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", stall_cnt, 0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // streaming 1..4 with no gaps
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 96'(i); in_ctrl = 16'(i * 16'h0101);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, 128'(i));
      chk("stream_ctrl", out_ctrl, 128'(i * 16'h0101));
      chk("stream_in_ready", in_ready, 1);
    end

    // bubble: control driven but no valid
    in_valid = 1'b0; in_ctrl = 16'hFFFF; in_data = 96'h77;
    tick();
    chk("bubble_valid", out_valid, 0);
    chk("bubble_ctrl", out_ctrl, 0);
    chk("bubble_data_held", out_data, 4);
    tick();
    chk("bubble_ctrl2", out_ctrl, 0);

    // stall with A, then B offered
    in_valid = 1'b1; in_data = 96'hA; in_ctrl = 16'h5;
    tick();
    chk("stall_load", out_data, 128'hA);
    out_ready = 1'b0; in_data = 96'hB; in_ctrl = 16'h6;
    #1;
    chk("stall_in_ready0", in_ready, SKID ? 1 : 0);
    tick();
    if (SKID) in_valid = 1'b0;
    #1;
    chk("stall_in_ready1", in_ready, 0);
    chk("stall_cnt1", stall_cnt, 1);
    tick(); tick();
    chk("stall_data", out_data, 128'hA);
    chk("stall_ctrl", out_ctrl, 128'h5);
    chk("stall_valid", out_valid, 1);
    chk("stall_cnt3", stall_cnt, 3);
    out_ready = 1'b1;
    tick();
    chk("release_data", out_data, 128'hB);
    chk("release_ctrl", out_ctrl, 128'h6);
    chk("release_valid", out_valid, 1);
    chk("release_cnt", stall_cnt, 3);
    in_valid = 1'b0;
    tick();
    chk("release_empty", out_valid, 0);

    // flush a full slot while offering 0xC
    in_valid = 1'b1; in_data = 96'hD; in_ctrl = 16'hFFFF;
    tick();
    chk("flush_pre_ctrl", out_ctrl, 128'hFFFF);
    flush = 1'b1; in_data = 96'hC; in_ctrl = 16'h1234; out_ready = 1'b0;
    tick();
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    chk("flush_data_held", out_data, 128'hD);
    chk("flush_no_cnt", stall_cnt, 3);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush_after_valid", out_valid, 0);
    chk("flush_after_data", out_data, 128'hD);

    // saturation of the 4-bit counter
    in_valid = 1'b1; in_data = 96'hE; in_ctrl = 16'h1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (11) tick();
    chk("sat_14", stall_cnt, 14);
    repeat (9) tick();
    chk("sat_15", stall_cnt, 15);
    chk("sat_data", out_data, 128'hE);

    // asynchronous reset mid-stall
    reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ctrl", out_ctrl, 0);
    chk("arst_cnt", stall_cnt, 0);
    reset = 1'b0; out_ready = 1'b1;
    tick();
    chk("arst_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
